pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_WAIT, default 16, giving the mem_busy cycle count at which mem_timeout sets.
REQ-002 The block SHALL have parameter REG_ADDR_W, default 4, giving the register-index width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 The block SHALL have port id_rn, id_rm  input  REG_ADDR_W each  source indices of the instruction in ID.
REQ-006 The block SHALL have port id_uses_rn, id_uses_rm  input  1 each  qualify id_rn and id_rm.
REQ-007 The block SHALL have port ex_rd  input  REG_ADDR_W  destination index of the instruction in EX.
REQ-008 The block SHALL have port ex_reg_write_enable, ex_mem_to_reg_select  input  1 each  EX-stage control from the ID/EX register.
REQ-009 The block SHALL have port branch_taken  input  1  resolved taken branch in EX.
REQ-010 The block SHALL have port mem_busy  input  1  data memory not ready.
REQ-011 The block SHALL have ports pc_stall, if_id_stall, id_ex_stall  output  1 each  hold PC, IF/ID and ID/EX respectively.
REQ-012 The block SHALL have ports if_id_flush, id_ex_bubble  output  1 each  flush IF/ID; load zero control into ID/EX.
REQ-013 The block SHALL have port mem_timeout  output  1  sticky error flag.
REQ-014 The block SHALL have ports stall_cycles  output  16 and flush_count  output  8  saturating performance counters.

Function
REQ-015 load_use SHALL equal ex_mem_to_reg_select & ex_reg_write_enable & ((id_uses_rn & id_rn==ex_rd) | (id_uses_rm & id_rm==ex_rd)).
REQ-016 The FSM SHALL have states RUN, MEM_WAIT and FLUSH; control outputs SHALL be combinational from state and inputs.
REQ-017 In RUN with mem_busy=1, the block SHALL assert pc_stall, if_id_stall and id_ex_stall, with next state MEM_WAIT.
REQ-018 In RUN with mem_busy=0 and branch_taken=1, the block SHALL assert if_id_flush and id_ex_bubble, with next state FLUSH.
REQ-019 In RUN with mem_busy=0, branch_taken=0 and load_use=1, the block SHALL assert pc_stall, if_id_stall and id_ex_bubble, and remain in RUN.
REQ-020 In RUN with no condition active, all control outputs SHALL be 0.
REQ-021 In MEM_WAIT with mem_busy=1, the block SHALL hold all three stalls and remain in MEM_WAIT.
REQ-022 In MEM_WAIT with mem_busy=0, the block SHALL behave exactly as RUN for that cycle, including next state.
REQ-023 In FLUSH with mem_busy=0, the block SHALL assert id_ex_bubble only, with next state RUN.
REQ-024 In FLUSH with mem_busy=1, the block SHALL assert all three stalls, keep id_ex_bubble=0, and remain in FLUSH so the bubble is deferred.
REQ-025 Priority SHALL be mem_busy > branch_taken > load_use.
REQ-026 A wait counter SHALL increment each cycle mem_busy=1 and clear when mem_busy=0.
REQ-027 mem_timeout SHALL set on the cycle the wait counter reaches MAX_WAIT and SHALL clear only on reset.
REQ-028 stall_cycles SHALL increment on each cycle pc_stall=1 and saturate at 0xFFFF.
REQ-029 flush_count SHALL increment on each cycle if_id_flush=1 and saturate at 0xFF.

Reset
REQ-030 While reset=0, state SHALL be RUN, and the wait counter, stall_cycles, flush_count and mem_timeout SHALL be 0, asynchronously.
REQ-031 During reset, all control outputs SHALL read 0 regardless of inputs.
REQ-032 Reset asserted mid-MEM_WAIT or mid-FLUSH SHALL abandon the pending stall or bubble.

Structure
REQ-033 The state enum (RUN=0, MEM_WAIT=1, FLUSH=2) and REG_ADDR_W default SHALL reside in a shared package, pipeline_ctrl_pkg.
REQ-034 The load_use comparison SHALL be a combinational sub-module, load_use_detect.

Verification
REQ-035 Load ex_rd=3 with ex_mem_to_reg_select=1 and ex_reg_write_enable=1, and id_rn=3 with id_uses_rn=1 -> pc_stall, if_id_stall and id_ex_bubble =1 for one cycle, and stall_cycles=1.
REQ-036 Same as REQ-035 with id_uses_rn=0 -> no stall; all outputs 0.
REQ-037 branch_taken=1 for one cycle -> if_id_flush=1 for 1 cycle, id_ex_bubble=1 for 2 cycles, and flush_count=1.
REQ-038 branch_taken=1 in RUN, then mem_busy=1 for 3 cycles in FLUSH -> stalls held for 3 cycles, then id_ex_bubble=1 for 1 cycle, then RUN.
REQ-039 mem_busy=1 for 16 cycles -> mem_timeout=1 and stays 1 after mem_busy drops, until reset=0.
REQ-040 reset=0 asserted in MEM_WAIT -> outputs and counters 0 immediately; after release, state is RUN.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller slice.
package pipeline_ctrl_pkg;

   localparam int REG_ADDR_W_DEF = 4;
   localparam int STALL_CNT_W    = 16;
   localparam int FLUSH_CNT_W    = 8;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FLUSH    = 2'd2
   } hz_state_e;

   typedef struct packed {
      logic pc_stall;
      logic if_id_stall;
      logic id_ex_stall;
      logic if_id_flush;
      logic id_ex_bubble;
   } hz_ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bus: pipeline status towards the controller, stall/flush controls and counters back.
interface pipeline_hazard_ctrl_if
   import pipeline_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
);
   logic [REG_ADDR_W-1:0]  id_rn;
   logic [REG_ADDR_W-1:0]  id_rm;
   logic                   id_uses_rn;
   logic                   id_uses_rm;
   logic [REG_ADDR_W-1:0]  ex_rd;
   logic                   ex_reg_write_enable;
   logic                   ex_mem_to_reg_select;
   logic                   branch_taken;
   logic                   mem_busy;
   logic                   pc_stall;
   logic                   if_id_stall;
   logic                   id_ex_stall;
   logic                   if_id_flush;
   logic                   id_ex_bubble;
   logic                   mem_timeout;
   logic [STALL_CNT_W-1:0] stall_cycles;
   logic [FLUSH_CNT_W-1:0] flush_count;

   modport master (
      output id_rn, id_rm, id_uses_rn, id_uses_rm, ex_rd,
             ex_reg_write_enable, ex_mem_to_reg_select, branch_taken, mem_busy,
      input  pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_bubble,
             mem_timeout, stall_cycles, flush_count
   );

   modport slave (
      input  id_rn, id_rm, id_uses_rn, id_uses_rm, ex_rd,
             ex_reg_write_enable, ex_mem_to_reg_select, branch_taken, mem_busy,
      output pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_bubble,
             mem_timeout, stall_cycles, flush_count
   );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// Load-use detector: a load in EX whose destination feeds a live source operand in ID.
module load_use_detect
   import pipeline_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
   input  logic [REG_ADDR_W-1:0] id_rn,
   input  logic [REG_ADDR_W-1:0] id_rm,
   input  logic                  id_uses_rn,
   input  logic                  id_uses_rm,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_reg_write_enable,
   input  logic                  ex_mem_to_reg_select,
   output logic                  load_use
);

   assign load_use = ex_mem_to_reg_select & ex_reg_write_enable &
                     ((id_uses_rn & (id_rn == ex_rd)) | (id_uses_rm & (id_rm == ex_rd)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush sequencing for memory waits, taken branches and load-use,
// plus a sticky memory-timeout flag and saturating performance counters.
module pipeline_hazard_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int MAX_WAIT   = 16,
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
   input logic             clk,
   input logic             reset,
   pipeline_hazard_ctrl_if.slave hz
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   hz_state_e              state_r;
   hz_state_e              next_state_s;
   hz_ctrl_t               ctrl_s;
   hz_ctrl_t               ctrl_out_s;
   logic                   load_use_s;
   logic [WAIT_W-1:0]      wait_cnt_r;
   logic                   mem_timeout_r;
   logic [STALL_CNT_W-1:0] stall_cycles_r;
   logic [FLUSH_CNT_W-1:0] flush_count_r;

   load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use (
      .id_rn                (hz.id_rn),
      .id_rm                (hz.id_rm),
      .id_uses_rn           (hz.id_uses_rn),
      .id_uses_rm           (hz.id_uses_rm),
      .ex_rd                (hz.ex_rd),
      .ex_reg_write_enable  (hz.ex_reg_write_enable),
      .ex_mem_to_reg_select (hz.ex_mem_to_reg_select),
      .load_use             (load_use_s)
   );

   // Next-state and control decode; MEM_WAIT without mem_busy is indistinguishable from RUN.
   always_comb begin
      ctrl_s       = '0;
      next_state_s = state_r;
      case (state_r)
         RUN, MEM_WAIT: begin
            if (hz.mem_busy) begin
               ctrl_s.pc_stall    = 1'b1;
               ctrl_s.if_id_stall = 1'b1;
               ctrl_s.id_ex_stall = 1'b1;
               next_state_s       = MEM_WAIT;
            end else if (hz.branch_taken) begin
               ctrl_s.if_id_flush  = 1'b1;
               ctrl_s.id_ex_bubble = 1'b1;
               next_state_s        = FLUSH;
            end else if (load_use_s) begin
               ctrl_s.pc_stall     = 1'b1;
               ctrl_s.if_id_stall  = 1'b1;
               ctrl_s.id_ex_bubble = 1'b1;
               next_state_s        = RUN;
            end else begin
               next_state_s = RUN;
            end
         end
         FLUSH: begin
            if (hz.mem_busy) begin
               ctrl_s.pc_stall    = 1'b1;
               ctrl_s.if_id_stall = 1'b1;
               ctrl_s.id_ex_stall = 1'b1;
               next_state_s       = FLUSH;
            end else begin
               ctrl_s.id_ex_bubble = 1'b1;
               next_state_s        = RUN;
            end
         end
         default: begin
            next_state_s = RUN;
         end
      endcase
   end

   // Controls are forced quiet while reset is held, whatever the inputs do.
   assign ctrl_out_s = reset ? ctrl_s : '0;

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= RUN;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Busy-run counter (saturates at MAX_WAIT) and sticky timeout set when the run reaches MAX_WAIT.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt_r    <= '0;
         mem_timeout_r <= 1'b0;
      end else if (hz.mem_busy) begin
         if (wait_cnt_r != WAIT_W'(MAX_WAIT)) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
         end else begin
            wait_cnt_r <= wait_cnt_r;
         end
         if (wait_cnt_r >= WAIT_W'(MAX_WAIT - 1)) begin
            mem_timeout_r <= 1'b1;
         end else begin
            mem_timeout_r <= mem_timeout_r;
         end
      end else begin
         wait_cnt_r    <= '0;
         mem_timeout_r <= mem_timeout_r;
      end
   end

   // Saturating performance counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cycles_r <= '0;
         flush_count_r  <= '0;
      end else begin
         if (ctrl_out_s.pc_stall && (stall_cycles_r != 16'hFFFF)) begin
            stall_cycles_r <= stall_cycles_r + 16'd1;
         end else begin
            stall_cycles_r <= stall_cycles_r;
         end
         if (ctrl_out_s.if_id_flush && (flush_count_r != 8'hFF)) begin
            flush_count_r <= flush_count_r + 8'd1;
         end else begin
            flush_count_r <= flush_count_r;
         end
      end
   end

   assign hz.pc_stall     = ctrl_out_s.pc_stall;
   assign hz.if_id_stall  = ctrl_out_s.if_id_stall;
   assign hz.id_ex_stall  = ctrl_out_s.id_ex_stall;
   assign hz.if_id_flush  = ctrl_out_s.if_id_flush;
   assign hz.id_ex_bubble = ctrl_out_s.id_ex_bubble;
   assign hz.mem_timeout  = mem_timeout_r;
   assign hz.stall_cycles = stall_cycles_r;
   assign hz.flush_count  = flush_count_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed plus random bench for pipeline_hazard_ctrl against a behavioural hazard model.
module tb_pipeline_hazard_ctrl;
   import pipeline_ctrl_pkg::*;

   localparam int MAX_WAIT = 16;
   localparam int RW       = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.REG_ADDR_W(RW)) hz ();

   pipeline_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .REG_ADDR_W(RW)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz.slave)
   );

   int n_checks = 0;
   int n_err    = 0;

   // Model: a branch leaves one bubble owed; memory busy freezes everything and defers that bubble.
   bit m_owed;
   int m_busy_run;
   int m_stalls;
   int m_flushes;
   bit m_tmo;
   bit e_pc, e_ifid, e_idex, e_fl, e_bub;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owed     = 1'b0;
      m_busy_run = 0;
      m_stalls   = 0;
      m_flushes  = 0;
      m_tmo      = 1'b0;
   endtask

   task automatic set_in(input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rd,
                         input bit urn, input bit urm, input bit we, input bit m2r,
                         input bit br, input bit busy);
      hz.id_rn                = rn;
      hz.id_rm                = rm;
      hz.ex_rd                = rd;
      hz.id_uses_rn           = urn;
      hz.id_uses_rm           = urm;
      hz.ex_reg_write_enable  = we;
      hz.ex_mem_to_reg_select = m2r;
      hz.branch_taken         = br;
      hz.mem_busy             = busy;
   endtask

   task automatic idle();
      set_in(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".pc_stall"},     32'(hz.pc_stall),     32'd0);
      check({tag, ".if_id_stall"},  32'(hz.if_id_stall),  32'd0);
      check({tag, ".id_ex_stall"},  32'(hz.id_ex_stall),  32'd0);
      check({tag, ".if_id_flush"},  32'(hz.if_id_flush),  32'd0);
      check({tag, ".id_ex_bubble"}, 32'(hz.id_ex_bubble), 32'd0);
      check({tag, ".mem_timeout"},  32'(hz.mem_timeout),  32'd0);
      check({tag, ".stall_cycles"}, 32'(hz.stall_cycles), 32'd0);
      check({tag, ".flush_count"},  32'(hz.flush_count),  32'd0);
   endtask

   // Called at a negedge with inputs applied; checks the cycle, clocks it, advances the model.
   task automatic step(input string tag);
      bit lu;
      #1;
      lu = hz.ex_mem_to_reg_select && hz.ex_reg_write_enable &&
           ((hz.id_uses_rn && (hz.id_rn == hz.ex_rd)) || (hz.id_uses_rm && (hz.id_rm == hz.ex_rd)));
      {e_pc, e_ifid, e_idex, e_fl, e_bub} = 5'b0;
      if (hz.mem_busy) begin
         {e_pc, e_ifid, e_idex} = 3'b111;
      end else if (m_owed) begin
         e_bub = 1'b1;
      end else if (hz.branch_taken) begin
         {e_fl, e_bub} = 2'b11;
      end else if (lu) begin
         {e_pc, e_ifid, e_bub} = 3'b111;
      end
      check({tag, ".pc_stall"},     32'(hz.pc_stall),     32'(e_pc));
      check({tag, ".if_id_stall"},  32'(hz.if_id_stall),  32'(e_ifid));
      check({tag, ".id_ex_stall"},  32'(hz.id_ex_stall),  32'(e_idex));
      check({tag, ".if_id_flush"},  32'(hz.if_id_flush),  32'(e_fl));
      check({tag, ".id_ex_bubble"}, 32'(hz.id_ex_bubble), 32'(e_bub));
      check({tag, ".mem_timeout"},  32'(hz.mem_timeout),  32'(m_tmo));
      check({tag, ".stall_cycles"}, 32'(hz.stall_cycles), 32'(m_stalls));
      check({tag, ".flush_count"},  32'(hz.flush_count),  32'(m_flushes));
      @(posedge clk);
      if (hz.mem_busy) begin
         m_busy_run++;
      end else begin
         m_busy_run = 0;
         if (m_owed) m_owed = 1'b0;
         else if (hz.branch_taken) m_owed = 1'b1;
      end
      if (m_busy_run >= MAX_WAIT) m_tmo = 1'b1;
      if (e_pc && m_stalls < 65535) m_stalls++;
      if (e_fl && m_flushes < 255) m_flushes++;
      @(negedge clk);
   endtask

   task automatic load_use_in(input bit urn);
      set_in(4'd3, 4'd0, 4'd3, urn, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      int burst;
      model_reset();
      // Reset held with every hazard input active: controls must stay quiet.
      set_in(4'd3, 4'd3, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      #2;
      check_all_zero("reset_hold");
      @(negedge clk);
      @(negedge clk);
      check_all_zero("reset_hold2");
      idle();
      reset = 1'b1;

      // Load-use hit, then the same with rn unqualified.
      load_use_in(1'b1);
      step("lu_hit");
      idle();
      check("lu_stall_cycles", 32'(hz.stall_cycles), 32'd1);
      step("lu_after");
      load_use_in(1'b0);
      step("lu_nouse");

      // Single taken branch: flush 1 cycle, bubble 2 cycles.
      set_in(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step("br");
      idle();
      step("br_flush_state");
      check("br_flush_count", 32'(hz.flush_count), 32'd1);
      step("br_done");

      // Branch followed by memory busy while the bubble is owed.
      set_in(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step("brm");
      for (int i = 0; i < 3; i++) begin
         set_in(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         step("brm_busy");
      end
      idle();
      step("brm_bubble");
      check("brm_bubble_done", 32'(hz.id_ex_bubble), 32'd0);
      step("brm_run");

      // Timeout boundary: 15 busy cycles leave it clear, the 16th sets it.
      for (int i = 0; i < MAX_WAIT - 1; i++) begin
         set_in(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         step("to_busy");
      end
      check("to_before", 32'(hz.mem_timeout), 32'd0);
      step("to_last");
      check("to_set", 32'(hz.mem_timeout), 32'd1);
      idle();
      for (int i = 0; i < 3; i++) step("to_sticky");
      check("to_sticky_after", 32'(hz.mem_timeout), 32'd1);

      // Reset mid MEM_WAIT with mem_busy still high.
      set_in(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step("rmw_busy");
      #2;
      reset = 1'b0;
      #1;
      check_all_zero("rmw_reset");
      model_reset();
      @(negedge clk);
      idle();
      reset = 1'b1;
      step("rmw_run");
      load_use_in(1'b1);
      step("rmw_lu");

      // Reset mid FLUSH: the owed bubble is abandoned.
      set_in(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step("rfl_br");
      #2;
      reset = 1'b0;
      #1;
      check_all_zero("rfl_reset");
      model_reset();
      @(negedge clk);
      idle();
      reset = 1'b1;
      step("rfl_nobubble");

      // Random traffic with occasional long busy bursts.
      burst = 0;
      for (int i = 0; i < 400; i++) begin
         if (burst == 0 && $urandom_range(0, 19) == 0) burst = $urandom_range(1, 20);
         set_in(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 5) == 0), (burst > 0) || ($urandom_range(0, 9) == 0));
         if (burst > 0) burst--;
         step("rnd");
      end

      // Continuous branches drive flush_count into saturation.
      set_in(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 540; i++) step("fsat");
      check("fsat_final", 32'(hz.flush_count), 32'd255);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
